dbus_responder: RTL

//  Target side of the core's data bus (DADDR/DATAO/DLEN/DRD/DWR/DAS in, DATAI/HLT/BERR out).

---
 rtl/dbus_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dbus_responder.sv
// Data-bus target: decodes core requests and drives a single-port word SRAM with byte enables.
// Latency: accept + WAIT_CYCLES + ACCESS + DONE for good requests; accept + DONE for errors.
// Backpressure: HLT stalls the core from accept through ACCESS and drops in DONE.
module dbus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8010_0000,
    parameter int          AW          = 14,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          DAS,
    input  logic          DRD,
    input  logic          DWR,
    input  logic [31:0]   DADDR,
    input  logic [2:0]    DLEN,
    input  logic [31:0]   DATAO,
    output logic [31:0]   DATAI,
    output logic          HLT,
    output logic          BERR,
    output logic          ram_en,
    output logic          ram_we,
    output logic [3:0]    ram_be,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t        state;
    logic [3:0]    cnt;
    logic [1:0]    off_q;
    logic [2:0]    len_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] waddr_q;

    logic          req;
    logic          len_ok;
    logic          misalign;
    logic          in_range;
    logic          bad;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [31:0]   rd_shift;

    assign req      = DAS & (DRD | DWR);
    assign len_ok   = (DLEN == 3'b001) | (DLEN == 3'b010) | (DLEN == 3'b100);
    assign misalign = ((DLEN == 3'b010) & DADDR[0]) | ((DLEN == 3'b100) & (|DADDR[1:0]));
    // Base is window-aligned, so the upper address bits alone decide the range.
    assign in_range = (DADDR[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign bad      = (DRD & DWR) | ~len_ok | misalign | ~in_range;

    assign HLT = ((state == S_IDLE) & req) | (state == S_WAIT) | (state == S_ACCESS);

    always_comb begin
        be_d    = 4'b0000;
        wdata_d = DATAO;
        case (DLEN)
            3'b001: begin
                be_d    = 4'b0001 << DADDR[1:0];
                wdata_d = {4{DATAO[7:0]}};
            end
            3'b010: begin
                be_d    = 4'b0011 << {DADDR[1], 1'b0};
                wdata_d = {2{DATAO[15:0]}};
            end
            default: be_d = 4'b1111;
        endcase
        if (!DWR) begin
            be_d = 4'b0000;
        end
    end

    // SRAM data only arrives in DONE, so read data is steered straight from ram_rdata.
    always_comb begin
        DATAI    = 32'h0;
        rd_shift = ram_rdata >> {off_q, 3'b000};
        if (state == S_DONE && !BERR && !we_q) begin
            case (len_q)
                3'b001:  DATAI = {24'h0, rd_shift[7:0]};
                3'b010:  DATAI = {16'h0, rd_shift[15:0]};
                default: DATAI = rd_shift;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            off_q     <= 2'd0;
            len_q     <= 3'd0;
            we_q      <= 1'b0;
            be_q      <= 4'd0;
            wdata_q   <= 32'h0;
            waddr_q   <= '0;
            BERR      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_be    <= 4'd0;
            ram_addr  <= '0;
            ram_wdata <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        off_q   <= DADDR[1:0];
                        len_q   <= DLEN;
                        we_q    <= DWR;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        waddr_q <= DADDR[AW+1:2];
                        if (bad) begin
                            BERR  <= 1'b1;
                            state <= S_DONE;
                        end else if (WAIT_CYCLES > 0) begin
                            cnt   <= WAIT_LOAD;
                            state <= S_WAIT;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_we    <= DWR;
                            ram_be    <= be_d;
                            ram_addr  <= DADDR[AW+1:2];
                            ram_wdata <= wdata_d;
                            state     <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        ram_en    <= 1'b1;
                        ram_we    <= we_q;
                        ram_be    <= be_q;
                        ram_addr  <= waddr_q;
                        ram_wdata <= wdata_q;
                        state     <= S_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= S_DONE;
                end
                default: begin
                    BERR  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
